// File: rtl/fetch_unit.sv
// Instruction fetch front end: issues in-order memory requests and queues the
// returned words for decode, dropping responses made stale by a redirect.
module fetch_unit #(
  parameter int DEPTH = 2
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [31:0] pc_i,
  output logic [31:0] next_pc_o,
  input  logic        redirect_i,
  input  logic [31:0] redirect_pc_i,
  input  logic        halt_i,
  output logic        imem_req_valid_o,
  output logic [31:0] imem_req_addr_o,
  input  logic        imem_req_ready_i,
  input  logic        imem_rsp_valid_i,
  input  logic [31:0] imem_rsp_data_i,
  output logic        if_valid_o,
  output logic [31:0] if_pc_o,
  output logic [31:0] if_instr_o,
  input  logic        if_ready_i
);

  localparam int CW = $clog2(DEPTH + 1);
  localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam logic [CW-1:0] DEPTH_C = CW'(DEPTH);
  localparam logic [CW:0]   DEPTH_W = (CW + 1)'(DEPTH);
  localparam logic [CW-1:0] ONE_C   = CW'(1);

  logic [CW-1:0] out_cnt;
  logic [CW-1:0] drop_cnt;
  logic [CW-1:0] buf_cnt;
  logic [CW-1:0] live_cnt;
  logic [CW:0]   occupancy;

  logic [PW-1:0] pcq_wr;
  logic [PW-1:0] pcq_rd;
  logic [PW-1:0] buf_wr;
  logic [PW-1:0] buf_rd;

  logic [31:0] pcq       [DEPTH];
  logic [31:0] buf_pc    [DEPTH];
  logic [31:0] buf_instr [DEPTH];

  logic issue;
  logic accept;
  logic rsp;
  logic buf_push;
  logic consume;
  logic unused_addr_bits;

  function automatic logic [PW-1:0] next_ptr(input logic [PW-1:0] p);
    return (p == PW'(DEPTH - 1)) ? '0 : p + PW'(1);
  endfunction

  // Stale in-flight requests do not count against buffer space: their
  // responses will be discarded and never occupy an entry.
  always_comb begin
    live_cnt  = out_cnt - drop_cnt;
    occupancy = {1'b0, live_cnt} + {1'b0, buf_cnt};
    issue     = rst_n && !redirect_i && !halt_i && (out_cnt < DEPTH_C) && (occupancy < DEPTH_W);
    accept    = issue && imem_req_ready_i;
    rsp       = imem_rsp_valid_i && (out_cnt != '0);
    buf_push  = rsp && (drop_cnt == '0) && !redirect_i;
    consume   = (buf_cnt != '0) && if_ready_i && !redirect_i;
    if (rst_n && redirect_i) begin
      next_pc_o = {redirect_pc_i[31:2], 2'b00};
    end else if (accept) begin
      next_pc_o = pc_i + 32'd4;
    end else begin
      next_pc_o = pc_i;
    end
  end

  assign unused_addr_bits = ^redirect_pc_i[1:0];

  assign imem_req_valid_o = issue;
  assign imem_req_addr_o  = pc_i;
  assign if_valid_o       = (buf_cnt != '0);
  assign if_pc_o          = if_valid_o ? buf_pc[buf_rd] : '0;
  assign if_instr_o       = if_valid_o ? buf_instr[buf_rd] : '0;

  always_ff @(posedge clk) begin
    if (accept) begin
      pcq[pcq_wr] <= pc_i;
    end
    if (buf_push) begin
      buf_pc[buf_wr]    <= pcq[pcq_rd];
      buf_instr[buf_wr] <= imem_rsp_data_i;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_cnt  <= '0;
      drop_cnt <= '0;
      buf_cnt  <= '0;
      pcq_wr   <= '0;
      pcq_rd   <= '0;
      buf_wr   <= '0;
      buf_rd   <= '0;
    end else begin
      if (accept) begin
        pcq_wr <= next_ptr(pcq_wr);
      end
      if (rsp) begin
        pcq_rd <= next_ptr(pcq_rd);
      end
      out_cnt <= out_cnt + CW'(accept) - CW'(rsp);

      // No request issues during a redirect, so everything still
      // outstanding after this cycle's response belongs to the old path.
      if (redirect_i) begin
        drop_cnt <= out_cnt - CW'(rsp);
      end else if (rsp && (drop_cnt != '0)) begin
        drop_cnt <= drop_cnt - ONE_C;
      end

      if (redirect_i) begin
        buf_cnt <= '0;
        buf_wr  <= '0;
        buf_rd  <= '0;
      end else begin
        if (buf_push) begin
          buf_wr <= next_ptr(buf_wr);
        end
        if (consume) begin
          buf_rd <= next_ptr(buf_rd);
        end
        buf_cnt <= buf_cnt + CW'(buf_push) - CW'(consume);
      end
    end
  end

  no_buf_overflow: assert property (@(posedge clk) disable iff (!rst_n)
    !(buf_push && !consume && (buf_cnt == DEPTH_C)));

  no_orphan_response: assert property (@(posedge clk) disable iff (!rst_n)
    !(imem_rsp_valid_i && (out_cnt == '0)));

endmodule

// File: tb/tb_fetch_unit.sv
// Bench for fetch_unit: directed scenarios then random traffic, all checked
// against a queue-based model of in-flight requests and buffered instructions.
module tb_fetch_unit;

  localparam int DEPTH = 3;

  logic        clk;
  logic        rst_n;
  logic [31:0] pc_i;
  logic [31:0] next_pc_o;
  logic        redirect_i;
  logic [31:0] redirect_pc_i;
  logic        halt_i;
  logic        imem_req_valid_o;
  logic [31:0] imem_req_addr_o;
  logic        imem_req_ready_i;
  logic        imem_rsp_valid_i;
  logic [31:0] imem_rsp_data_i;
  logic        if_valid_o;
  logic [31:0] if_pc_o;
  logic [31:0] if_instr_o;
  logic        if_ready_i;

  fetch_unit #(.DEPTH(DEPTH)) dut (
    .clk              (clk),
    .rst_n            (rst_n),
    .pc_i             (pc_i),
    .next_pc_o        (next_pc_o),
    .redirect_i       (redirect_i),
    .redirect_pc_i    (redirect_pc_i),
    .halt_i           (halt_i),
    .imem_req_valid_o (imem_req_valid_o),
    .imem_req_addr_o  (imem_req_addr_o),
    .imem_req_ready_i (imem_req_ready_i),
    .imem_rsp_valid_i (imem_rsp_valid_i),
    .imem_rsp_data_i  (imem_rsp_data_i),
    .if_valid_o       (if_valid_o),
    .if_pc_o          (if_pc_o),
    .if_instr_o       (if_instr_o),
    .if_ready_i       (if_ready_i)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [31:0] pc;
    bit          stale;
    int          cycle;
  } flight_t;

  typedef struct {
    logic [31:0] pc;
    logic [31:0] instr;
  } instr_t;

  // Requests the memory has accepted but not yet answered, oldest first,
  // and instructions waiting for decode, oldest first.
  flight_t inflight[$];
  instr_t  ibuf[$];

  logic [31:0] pc;
  int          cyc;
  int          check_cnt;
  int          pass_cnt;

  int          p_ready;
  int          p_rsp;
  int          p_ifready;
  int          p_halt;
  int          p_redirect;
  bit          mem_hold;
  bit          use_fixed;
  logic [31:0] fixed_target;

  bit          exp_valid;
  bit          exp_accept;
  bit          exp_consume;
  logic [31:0] exp_next;

  task automatic checkValue(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    check_cnt++;
    assert (obs === exp) begin
      pass_cnt++;
    end else begin
      $error("[TB] FAIL %s observed=0x%08h expected=0x%08h", tag, obs, exp);
    end
  endtask

  task automatic setKnobs(input int ready, input int rspp, input int ifready, input int halt, input int redir);
    p_ready    = ready;
    p_rsp      = rspp;
    p_ifready  = ifready;
    p_halt     = halt;
    p_redirect = redir;
  endtask

  task automatic applyStimulus();
    pc_i             = pc;
    redirect_i       = ($urandom_range(99) < p_redirect);
    redirect_pc_i    = use_fixed ? fixed_target : $urandom;
    halt_i           = ($urandom_range(99) < p_halt);
    imem_req_ready_i = ($urandom_range(99) < p_ready);
    if_ready_i       = ($urandom_range(99) < p_ifready);
    imem_rsp_valid_i = !mem_hold && (inflight.size() != 0) && (inflight[0].cycle < cyc)
                       && ($urandom_range(99) < p_rsp);
    imem_rsp_data_i  = $urandom;
    #1;
  endtask

  task automatic checkOutput();
    int live;
    live = 0;
    foreach (inflight[i]) begin
      if (!inflight[i].stale) live++;
    end
    exp_valid   = !redirect_i && !halt_i && (inflight.size() < DEPTH) && (live + ibuf.size() < DEPTH);
    exp_accept  = exp_valid && imem_req_ready_i;
    exp_consume = (ibuf.size() != 0) && if_ready_i && !redirect_i;
    if (redirect_i) exp_next = {redirect_pc_i[31:2], 2'b00};
    else if (exp_accept) exp_next = pc + 32'd4;
    else exp_next = pc;

    checkValue("req_valid", 32'(imem_req_valid_o), 32'(exp_valid));
    if (exp_valid) checkValue("req_addr", imem_req_addr_o, pc);
    checkValue("next_pc", next_pc_o, exp_next);
    checkValue("if_valid", 32'(if_valid_o), 32'(ibuf.size() != 0));
    if (ibuf.size() != 0) begin
      checkValue("if_pc", if_pc_o, ibuf[0].pc);
      checkValue("if_instr", if_instr_o, ibuf[0].instr);
    end
  endtask

  task automatic commitCycle();
    flight_t f;
    instr_t  e;
    @(posedge clk);
    if (exp_consume) void'(ibuf.pop_front());
    if (imem_rsp_valid_i) begin
      f = inflight.pop_front();
      if (!f.stale && !redirect_i) begin
        e.pc    = f.pc;
        e.instr = imem_rsp_data_i;
        ibuf.push_back(e);
      end
    end
    if (redirect_i) begin
      ibuf.delete();
      foreach (inflight[i]) inflight[i].stale = 1'b1;
    end
    if (exp_accept) begin
      f.pc    = pc;
      f.stale = 1'b0;
      f.cycle = cyc;
      inflight.push_back(f);
    end
    pc = exp_next;
    cyc++;
    @(negedge clk);
  endtask

  task automatic runCycle();
    applyStimulus();
    checkOutput();
    commitCycle();
  endtask

  // Reset is applied asynchronously half-way through a cycle; the memory
  // forgets its in-flight requests along with the block.
  task automatic doReset();
    logic [31:0] held_pc;
    rst_n            = 1'b0;
    pc_i             = $urandom;
    redirect_i       = 1'b1;
    redirect_pc_i    = $urandom;
    halt_i           = 1'b0;
    imem_req_ready_i = 1'b1;
    imem_rsp_valid_i = 1'b0;
    if_ready_i       = 1'b1;
    #1;
    held_pc = pc_i;
    checkValue("rst_if_valid", 32'(if_valid_o), 32'd0);
    checkValue("rst_req_valid", 32'(imem_req_valid_o), 32'd0);
    checkValue("rst_if_pc", if_pc_o, 32'd0);
    checkValue("rst_if_instr", if_instr_o, 32'd0);
    checkValue("rst_next_pc", next_pc_o, held_pc);
    inflight.delete();
    ibuf.delete();
    @(negedge clk);
    rst_n      = 1'b1;
    redirect_i = 1'b0;
    pc         = 32'd0;
    cyc        = 0;
  endtask

  initial begin
    #200000;
    $display("[TB] FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    int  delivered;
    int  req_seen;
    bit  found;

    rst_n = 1'b0;
    pc_i = '0; redirect_i = 1'b0; redirect_pc_i = '0; halt_i = 1'b0;
    imem_req_ready_i = 1'b0; imem_rsp_valid_i = 1'b0; imem_rsp_data_i = '0; if_ready_i = 1'b0;
    check_cnt = 0; pass_cnt = 0; pc = '0; cyc = 0;
    mem_hold = 1'b0; use_fixed = 1'b0; fixed_target = '0;
    setKnobs(100, 100, 100, 0, 0);
    @(negedge clk);

    // Zero-wait memory, decode always ready: steady one instruction per cycle.
    doReset();
    runCycle();
    runCycle();
    applyStimulus();
    checkOutput();
    checkValue("zw_first_valid", 32'(if_valid_o), 32'd1);
    checkValue("zw_first_pc", if_pc_o, 32'd0);
    commitCycle();
    delivered = 0;
    for (int i = 0; i < 10; i++) begin
      applyStimulus();
      checkOutput();
      if (if_valid_o && if_ready_i) delivered++;
      commitCycle();
    end
    checkValue("zw_rate", 32'(delivered), 32'd10);

    // Decode stalled: fetch fills up to DEPTH and stops, head held at 0x0.
    doReset();
    setKnobs(100, 100, 0, 0, 0);
    for (int i = 0; i < 5; i++) runCycle();
    applyStimulus();
    checkOutput();
    checkValue("full_req_valid", 32'(imem_req_valid_o), 32'd0);
    checkValue("full_if_valid", 32'(if_valid_o), 32'd1);
    checkValue("full_if_pc", if_pc_o, 32'd0);
    commitCycle();

    // Redirect with two requests outstanding.
    doReset();
    setKnobs(100, 100, 100, 0, 0);
    mem_hold = 1'b1;
    runCycle();
    runCycle();
    use_fixed = 1'b1;
    fixed_target = 32'h0000_0103;
    setKnobs(100, 100, 100, 0, 100);
    applyStimulus();
    checkOutput();
    checkValue("redir_next_pc", next_pc_o, 32'h0000_0100);
    checkValue("redir_no_req", 32'(imem_req_valid_o), 32'd0);
    commitCycle();
    setKnobs(100, 100, 100, 0, 0);
    mem_hold = 1'b0;
    found = 1'b0;
    for (int i = 0; i < 20 && !found; i++) begin
      applyStimulus();
      checkOutput();
      if (if_valid_o) begin
        found = 1'b1;
        checkValue("redir_first_pc", if_pc_o, 32'h0000_0100);
      end
      commitCycle();
    end
    if (!found) checkValue("redir_timeout", 32'd0, 32'd1);

    // PC wrap at the top of the address space.
    fixed_target = 32'hFFFF_FFFC;
    setKnobs(100, 100, 100, 0, 100);
    runCycle();
    setKnobs(100, 100, 100, 0, 0);
    applyStimulus();
    checkOutput();
    checkValue("wrap_req_addr", imem_req_addr_o, 32'hFFFF_FFFC);
    checkValue("wrap_next_pc", next_pc_o, 32'h0000_0000);
    commitCycle();
    for (int i = 0; i < 4; i++) runCycle();
    use_fixed = 1'b0;

    // Halt with one request in flight: no new request, pending one delivered.
    doReset();
    mem_hold = 1'b1;
    runCycle();
    mem_hold = 1'b0;
    setKnobs(100, 100, 100, 100, 0);
    found = 1'b0;
    req_seen = 0;
    for (int i = 0; i < 10 && !found; i++) begin
      applyStimulus();
      checkOutput();
      if (imem_req_valid_o) req_seen++;
      if (if_valid_o) begin
        found = 1'b1;
        checkValue("halt_pc", if_pc_o, 32'd0);
      end
      commitCycle();
    end
    if (!found) checkValue("halt_timeout", 32'd0, 32'd1);
    checkValue("halt_no_req", 32'(req_seen), 32'd0);

    // Reset while the buffer holds instructions and one request is in flight.
    doReset();
    setKnobs(100, 100, 0, 0, 0);
    for (int i = 0; i < 3; i++) runCycle();
    mem_hold = 1'b1;
    runCycle();
    mem_hold = 1'b0;
    #2;
    doReset();
    setKnobs(100, 100, 100, 0, 0);
    applyStimulus();
    checkOutput();
    checkValue("post_rst_valid", 32'(imem_req_valid_o), 32'd1);
    checkValue("post_rst_addr", imem_req_addr_o, 32'd0);
    commitCycle();

    // Random traffic with occasional redirects, halts and resets.
    setKnobs(75, 60, 65, 10, 6);
    for (int i = 0; i < 600; i++) begin
      if (i % 200 == 199) doReset();
      runCycle();
    end

    $display("%0d/%0d checks passed", pass_cnt, check_cnt);
    $finish;
  end

endmodule
